riscv_imem_fetch: RTL
=====================

// Module: riscv_imem_fetch
// PURPOSE
// Instruction-memory responder; the consumer of the PC word address. Accepts one
// fetch per handshake, reads a word-addressed instruction RAM and returns the
// 32-bit instruction after a fixed latency, holding it until the core takes it.
// Includes a program-load write port and a flush input for taken branches/jumps.
// PARAMETERS
// ADDR_W        8             word-address width; matches the 8-bit PC output
// DEPTH         256           implemented words; addresses >= DEPTH are out of range
// READ_LATENCY  1             cycles from accept to instr_valid; legal 1..4
// NOP_INSTR     32'h00000013  returned for out-of-range fetches (addi x0,x0,0)
// PORTS
// clk           in   1       rising-edge clock
// rst           in   1       synchronous, active-high reset
// fetch_req     in   1       fetch request; fetch_addr valid while high
// fetch_addr    in   ADDR_W  instruction word address (PC value)
// fetch_ready   out  1       responder can accept a request this cycle
// instr_valid   out  1       instr/instr_err valid
// instr_ready   in   1       core consumes instr this cycle
// instr         out  32      fetched instruction
// instr_err     out  1       fetched address was out of range
// flush         in   1       discard any outstanding/held fetch
// prog_we       in   1       program-load write enable
// prog_addr     in   ADDR_W  program-load word address
// prog_data     in   32      program-load data
// BEHAVIOUR
// - Reset: state IDLE, instr_valid=0, instr=0, instr_err=0, latency counter 0.
//   RAM contents not reset. rst overrides every other input.
// - States: IDLE (no fetch), BUSY (latency count running), HOLD (instr_valid=1).
// - fetch_ready = !flush && (IDLE || (HOLD && instr_ready)); combinational.
// - Accept = fetch_req && fetch_ready. Accept in cycle c: RAM word read at the
//   edge ending c; instr_valid=1 from cycle c+READ_LATENCY. Latency 1: IDLE->HOLD
//   directly; else IDLE->BUSY, count READ_LATENCY-1 cycles, ->HOLD.
// - HOLD: instr/instr_err stable while instr_valid && !instr_ready. instr_ready
//   with no accept -> IDLE, instr_valid=0 next cycle. instr_ready with accept
//   (back-to-back) -> new fetch; latency 1 gives one instruction per cycle.
// - One fetch outstanding at most; fetch_req in BUSY ignored (fetch_ready=0).
// - Out of range (fetch_addr >= DEPTH): instr=NOP_INSTR, instr_err=1, same
//   latency; otherwise instr_err=0. Never X on instr.
// - Writes: prog_we writes prog_data at edge if prog_addr < DEPTH, else dropped.
//   Allowed in any state. Same-address write in the accept cycle: fetch returns
//   OLD data (read-before-write); new data visible from following accept.
// - flush (priority below rst): next state IDLE, instr_valid=0 next cycle, held
//   or in-flight result discarded, never presented; no accept in flush cycle.
//   flush concurrent with instr_ready in HOLD: consume, return IDLE.
// - instr_ready while instr_valid=0: ignored.
// TESTING
// - Load 0x00500093 @3, 0x00A00113 @4; fetch 3 with instr_ready=1, LAT=1 ->
//   instr_valid next cycle, instr=0x00500093; fetch 4 back-to-back -> 0x00A00113.
// - LAT=3, fetch addr 3 in cycle 10 -> instr_valid low cycles 11-12, high at 13.
// - instr_ready=0 for 5 cycles in HOLD -> instr/instr_valid stable, fetch_ready=0;
//   ready=1 -> released, next fetch accepted same cycle.
// - DEPTH=16, fetch addr 20 -> instr=0x00000013, instr_err=1; addr 15 -> err=0.
// - LAT=3, flush one cycle after accept -> instr_valid never rises; next fetch
//   of addr 4 returns 0x00A00113 with normal latency.
// - prog_we @5 = 0xDEADBEEF in same cycle as fetch of 5 (old 0x11111111) ->
//   returns 0x11111111; re-fetch 5 -> 0xDEADBEEF. rst in BUSY -> valid stays 0.

Source files
------------

// File: rtl/riscv_imem_fetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : riscv_imem_fetch_if
// Brief    : Fetch request / instruction response bundle between core and
//            instruction-memory responder.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface riscv_imem_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              instr_err;

  // Core side: issues fetches, consumes instructions
  modport master (
    output fetch_req, fetch_addr, instr_ready,
    input  fetch_ready, instr_valid, instr, instr_err
  );

  // Memory side: accepts fetches, returns instructions
  modport slave (
    input  fetch_req, fetch_addr, instr_ready,
    output fetch_ready, instr_valid, instr, instr_err
  );
endinterface
`default_nettype wire

// File: rtl/riscv_imem_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : riscv_imem_fetch
// Brief    : Word-addressed instruction RAM responder. One fetch outstanding,
//            fixed read latency, result held until the core takes it.
//            Program-load write port and branch flush.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module riscv_imem_fetch #(
  parameter int          ADDR_W       = 8,
  parameter int          DEPTH        = 256,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  wire logic              clk,
  input  wire logic              rst,
  riscv_imem_fetch_if.slave      bus,
  input  wire logic              flush,
  input  wire logic              prog_we,
  input  wire logic [ADDR_W-1:0] prog_addr,
  input  wire logic [31:0]       prog_data
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U  = DEPTH;
  // BUSY lasts READ_LATENCY-1 cycles; the count leaves BUSY when it reaches this
  localparam logic [1:0]  LAST_CNT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        accept;
  logic        fetch_in_range;
  logic        prog_in_range;
  logic [31:0] fetch_addr_ext;
  logic [31:0] prog_addr_ext;
  logic [31:0] mem [DEPTH];

  assign fetch_addr_ext = 32'(bus.fetch_addr);
  assign prog_addr_ext  = 32'(prog_addr);
  assign fetch_in_range = (fetch_addr_ext < DEPTH_U);
  assign prog_in_range  = (prog_addr_ext < DEPTH_U);

  // Handshake decode and next-state selection; flush beats any accept
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    bus.fetch_ready = !flush && ((state == IDLE) || ((state == HOLD) && bus.instr_ready));
    bus.instr_valid = (state == HOLD);
    accept          = bus.fetch_req && bus.fetch_ready;
    case (state)
      IDLE: state_nxt = IDLE;
      BUSY: begin
        if (cnt == LAST_CNT) state_nxt = HOLD;
        else                 cnt_nxt   = cnt + 2'd1;
      end
      HOLD: begin
        if (bus.instr_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      state_nxt = (READ_LATENCY == 1) ? HOLD : BUSY;
      cnt_nxt   = 2'd0;
    end
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
    end
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the read word at the accept edge; it stays put until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instr     <= 32'd0;
      bus.instr_err <= 1'b0;
    end else if (accept) begin
      bus.instr     <= fetch_in_range ? mem[bus.fetch_addr[IDX_W-1:0]] : NOP_INSTR;
      bus.instr_err <= !fetch_in_range;
    end
  end

  // Program-load port; same-edge read above sees the old word
  always_ff @(posedge clk) begin
    if (!rst && prog_we && prog_in_range) begin
      mem[prog_addr[IDX_W-1:0]] <= prog_data;
    end
  end

endmodule
`default_nettype wire
